// File: rtl/irrigation_countdown_timer.sv
// irrigation_countdown_timer: BCD MM:SS irrigation countdown with preset reload; optional pause via IRRIGATION_TIMER_PAUSE_EN
module irrigation_countdown_timer #(
  parameter int SPRINKLER_MM = 15,
  parameter int SPRINKLER_SS = 0,
  parameter int DRIPPER_MM   = 30,
  parameter int DRIPPER_SS   = 0,
  parameter int TICK_DIV     = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       irrigation_on,
  input  logic       forced_reset_n,
  input  logic       conflicting_values,
  input  logic       sprinkler_mode_on,
`ifdef IRRIGATION_TIMER_PAUSE_EN
  input  logic       pause,
`endif
  output logic [1:0] minutes_d,
  output logic [3:0] minutes_u,
  output logic [2:0] seconds_d,
  output logic [3:0] seconds_u,
  output logic       running,
  output logic       expired
);
  localparam int PW = TICK_DIV > 2 ? $clog2(TICK_DIV) : 1;
  localparam logic [1:0] S_MD = 2'(SPRINKLER_MM / 10);
  localparam logic [3:0] S_MU = 4'(SPRINKLER_MM % 10);
  localparam logic [2:0] S_SD = 3'(SPRINKLER_SS / 10);
  localparam logic [3:0] S_SU = 4'(SPRINKLER_SS % 10);
  localparam logic [1:0] D_MD = 2'(DRIPPER_MM / 10);
  localparam logic [3:0] D_MU = 4'(DRIPPER_MM % 10);
  localparam logic [2:0] D_SD = 3'(DRIPPER_SS / 10);
  localparam logic [3:0] D_SU = 4'(DRIPPER_SS % 10);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [PW-1:0] presc, presc_nx;
  logic [1:0] md_nx, dec_md;
  logic [3:0] mu_nx, dec_mu, su_nx, dec_su;
  logic [2:0] sd_nx, dec_sd;
  logic mode_q, reload_req, mode_chg, tick, zero, frozen, su0, sd0, mu0;
  assign reload_req = !irrigation_on || !forced_reset_n || conflicting_values;
  assign mode_chg   = sprinkler_mode_on != mode_q;
  assign tick       = presc == PW'(TICK_DIV - 1);
`ifdef IRRIGATION_TIMER_PAUSE_EN
  assign frozen = pause;
`else
  assign frozen = 1'b0;
`endif
  assign su0    = seconds_u == 4'd0;
  assign sd0    = seconds_d == 3'd0;
  assign mu0    = minutes_u == 4'd0;
  assign zero   = su0 && sd0 && mu0 && minutes_d == 2'd0;
  assign dec_su = su0 ? 4'd9 : seconds_u - 4'd1;
  assign dec_sd = su0 ? (sd0 ? 3'd5 : seconds_d - 3'd1) : seconds_d;
  assign dec_mu = (su0 && sd0) ? (mu0 ? 4'd9 : minutes_u - 4'd1) : minutes_u;
  assign dec_md = (su0 && sd0 && mu0) ? minutes_d - 2'd1 : minutes_d;
  assign running = state == RUN;
  assign expired = state == DONE;
  // next state, prescaler and digits: reload > mode change > pause > tick
  always_comb begin
    state_nx = state;
    presc_nx = presc;
    md_nx    = minutes_d;
    mu_nx    = minutes_u;
    sd_nx    = seconds_d;
    su_nx    = seconds_u;
    case (state)
      RUN:     state_nx = reload_req ? IDLE : (!mode_chg && !frozen && tick && zero) ? DONE : RUN;
      default: state_nx = reload_req ? IDLE : RUN;
    endcase
    if (state != RUN || reload_req || mode_chg) begin
      presc_nx = '0;
      md_nx    = sprinkler_mode_on ? S_MD : D_MD;
      mu_nx    = sprinkler_mode_on ? S_MU : D_MU;
      sd_nx    = sprinkler_mode_on ? S_SD : D_SD;
      su_nx    = sprinkler_mode_on ? S_SU : D_SU;
    end else if (!frozen) begin
      presc_nx = tick ? '0 : presc + PW'(1);
      if (tick && !zero) begin
        md_nx = dec_md;
        mu_nx = dec_mu;
        sd_nx = dec_sd;
        su_nx = dec_su;
      end
    end
  end
  // state, prescaler, digit and mode-history registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      presc     <= '0;
      minutes_d <= '0;
      minutes_u <= '0;
      seconds_d <= '0;
      seconds_u <= '0;
      mode_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      presc     <= presc_nx;
      minutes_d <= md_nx;
      minutes_u <= mu_nx;
      seconds_d <= sd_nx;
      seconds_u <= su_nx;
      mode_q    <= sprinkler_mode_on;
    end
  end
endmodule

// File: tb/tb_irrigation_countdown_timer.sv
// tb_irrigation_countdown_timer: scoreboard bench for irrigation_countdown_timer (TICK_DIV=4)
module tb_irrigation_countdown_timer;
  logic clk = 1'b0;
  logic rst_n, irrigation_on, forced_reset_n, conflicting_values, sprinkler_mode_on;
  logic [1:0] minutes_d;
  logic [3:0] minutes_u, seconds_u;
  logic [2:0] seconds_d;
  logic running, expired;
`ifdef IRRIGATION_TIMER_PAUSE_EN
  logic pause;
`endif
  irrigation_countdown_timer #(.TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .irrigation_on(irrigation_on), .forced_reset_n(forced_reset_n),
    .conflicting_values(conflicting_values), .sprinkler_mode_on(sprinkler_mode_on),
`ifdef IRRIGATION_TIMER_PAUSE_EN
    .pause(pause),
`endif
    .minutes_d(minutes_d), .minutes_u(minutes_u), .seconds_d(seconds_d), .seconds_u(seconds_u),
    .running(running), .expired(expired)
  );
  always #5 clk = ~clk;
  typedef struct {int cyc; logic [14:0] val; string name;} exp_t;
  exp_t q[$];
  int cyc = 0, checks = 0, errors = 0, exp_cnt = 0, e, c;
  logic [14:0] obs;
  assign obs = {running, expired, minutes_d, minutes_u, seconds_d, seconds_u};
  always @(posedge clk) cyc++;
  function automatic logic [14:0] mk(logic r, logic x, int mm, int ss);
    return {r, x, 2'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10)};
  endfunction
  task automatic check(string n, logic [14:0] act, logic [14:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got %h want %h", n, cyc, act, want);
    end
  endtask
  task automatic pusha(int at, string n, logic r, logic x, int mm, int ss);
    q.push_back('{at, mk(r, x, mm, ss), n});
  endtask
  task automatic goto(int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask
  // monitor: pops every expectation due this cycle and compares at the falling edge
  always @(negedge clk) begin
    exp_t h;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      h = q.pop_front();
      if (h.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s missed at cyc=%0d", h.name, h.cyc);
      end else check(h.name, obs, h.val);
    end
    if (expired) exp_cnt++;
  end
  initial begin
    rst_n = 1'b0; irrigation_on = 1'b0; forced_reset_n = 1'b1;
    conflicting_values = 1'b0; sprinkler_mode_on = 1'b1;
`ifdef IRRIGATION_TIMER_PAUSE_EN
    pause = 1'b0;
`endif
    @(posedge clk); #1;
    pusha(cyc, "reset", 0, 0, 0, 0);
    pusha(cyc + 1, "idle_preset", 0, 0, 15, 0);
    pusha(cyc + 3, "idle_hold", 0, 0, 15, 0);
    rst_n = 1'b1;
    goto(cyc + 3);
    irrigation_on = 1'b1;
    e = cyc + 1;
    pusha(e, "run_entry", 1, 0, 15, 0);
    pusha(e + 3, "pre_tick", 1, 0, 15, 0);
    pusha(e + 4, "first_dec", 1, 0, 14, 59);
    pusha(e + 240, "min_14", 1, 0, 14, 0);
    pusha(e + 1200, "min_10", 1, 0, 10, 0);
    pusha(e + 1204, "borrow_md", 1, 0, 9, 59);
    pusha(e + 3360, "min_1", 1, 0, 1, 0);
    pusha(e + 3364, "borrow_mu", 1, 0, 0, 59);
    pusha(e + 3600, "zero", 1, 0, 0, 0);
    pusha(e + 3604, "expire", 0, 1, 0, 0);
    pusha(e + 3605, "rearm", 1, 0, 15, 0);
    pusha(e + 3606, "pulse_end", 1, 0, 15, 0);
    goto(e + 3605);
    e = e + 3605;
    for (int s = 0; s < 3; s++) begin
      goto(e + 584);
      c = cyc;
      pusha(c, "mid_1234", 1, 0, 12, 34);
      pusha(c + 1, "reload_idle", 0, 0, 15, 0);
      pusha(c + 2, "reload_run", 1, 0, 15, 0);
      if (s == 0) forced_reset_n = 1'b0;
      else if (s == 1) conflicting_values = 1'b1;
      else irrigation_on = 1'b0;
      goto(c + 1);
      forced_reset_n = 1'b1; conflicting_values = 1'b0; irrigation_on = 1'b1;
      e = c + 2;
    end
    goto(e + 1172);
    c = cyc;
    pusha(c, "pre_mode", 1, 0, 10, 7);
    pusha(c + 1, "mode_load", 1, 0, 30, 0);
    pusha(c + 4, "mode_hold", 1, 0, 30, 0);
    pusha(c + 5, "mode_dec", 1, 0, 29, 59);
    sprinkler_mode_on = 1'b0;
    e = c + 1;
    pusha(e + 5356, "pre_rst", 1, 0, 7, 41);
    goto(e + 5356);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst", obs, 15'd0);
    @(posedge clk); #1;
    pusha(cyc, "rst_hold", 0, 0, 0, 0);
    pusha(cyc + 1, "rst_rerun", 1, 0, 30, 0);
    rst_n = 1'b1;
    e = cyc + 1;
    pusha(e + 4, "dec_after_rst", 1, 0, 29, 59);
`ifdef IRRIGATION_TIMER_PAUSE_EN
    goto(e + 6);
    pause = 1'b1;
    pusha(e + 26, "paused", 1, 0, 29, 59);
    pusha(e + 27, "resume_wait", 1, 0, 29, 59);
    pusha(e + 28, "resume_dec", 1, 0, 29, 58);
    goto(e + 26);
    pause = 1'b0;
    goto(e + 28);
`else
    goto(e + 4);
`endif
    goto(cyc + 2);
    @(negedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want 0", q.size());
    end
    checks++;
    if (exp_cnt != 1) begin
      errors++;
      $display("FAIL expired_count got %0d want 1", exp_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
